// File: rtl/isa_pkg.sv
// Shared ISA definitions for the register-bank issue controller: opcodes,
// instruction field positions and the issue FSM state encoding.
package isa_pkg;

   localparam logic [5:0] OP_NOP = 6'h00;
   localparam logic [5:0] OP_RR  = 6'h01;
   localparam logic [5:0] OP_MOV = 6'h02;
   localparam logic [5:0] OP_LDI = 6'h03;
   localparam logic [5:0] OP_RD  = 6'h04;

   // imm overlaps rt/rd; LDI simply reuses the low 20 bits of the word.
   localparam int OP_MSB  = 31;
   localparam int OP_LSB  = 26;
   localparam int RS_MSB  = 25;
   localparam int RS_LSB  = 21;
   localparam int RT_MSB  = 20;
   localparam int RT_LSB  = 16;
   localparam int RD_MSB  = 15;
   localparam int RD_LSB  = 11;
   localparam int IMM_MSB = 19;
   localparam int IMM_LSB = 0;
   localparam int IMM_W   = 20;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DECODE = 3'd1,
      ST_READ   = 3'd2,
      ST_EXEC   = 3'd3,
      ST_WB     = 3'd4,
      ST_MOVE   = 3'd5,
      ST_LDIMM  = 3'd6,
      ST_RSVD   = 3'd7
   } state_t;

endpackage

// File: rtl/issue_op_decode.sv
// Classifies an opcode into the state that follows DECODE and flags
// opcodes that have no defined behaviour.
module issue_op_decode
   import isa_pkg::*;
(
   input  logic [5:0] i_op,
   output logic [2:0] o_next_state,
   output logic       o_illegal
);

   always_comb begin
      o_next_state = ST_IDLE;
      o_illegal    = 1'b0;
      case (i_op)
         OP_NOP: o_next_state = ST_IDLE;
         OP_RR:  o_next_state = ST_READ;
         OP_MOV: o_next_state = ST_MOVE;
         OP_LDI: o_next_state = ST_LDIMM;
         OP_RD:  o_next_state = ST_READ;
         default: begin
            o_next_state = ST_IDLE;
            o_illegal    = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/reg_bank_issue_ctrl.sv
// Decode-and-issue controller in front of the register bank: accepts one
// instruction at a time and sequences bank strobes plus the external ALU.
module reg_bank_issue_ctrl
   import isa_pkg::*;
#(
   parameter int word_size        = 32,
   parameter int reg_address_size = 5,
   parameter int alu_timeout      = 15,
   parameter int count_size       = 16
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [31:0]                 instr_in,
   input  logic                        instr_valid,
   output logic                        instr_ready,
   output logic [reg_address_size-1:0] rs_address,
   output logic [reg_address_size-1:0] rt_address,
   output logic [reg_address_size-1:0] rd_address,
   output logic [word_size-1:0]        data_out,
   output logic                        load,
   output logic                        store,
   output logic                        load_reg_i,
   output logic                        load_rd_i,
   output logic                        alu_start,
   input  logic [word_size-1:0]        alu_result,
   input  logic                        alu_done,
   output logic                        busy,
   output logic                        illegal_op,
   output logic [count_size-1:0]       retired,
   output logic [2:0]                  state_dbg
);

   localparam int                    TW       = $clog2(alu_timeout + 1);
   localparam logic [TW-1:0]         TMO_LAST = TW'(alu_timeout - 1);
   localparam logic [TW-1:0]         TMO_ONE  = TW'(1);
   localparam logic [count_size-1:0] CNT_ONE  = count_size'(1);

   state_t        r_state;
   logic [5:0]    r_op;
   logic [TW-1:0] r_tmo;
   logic [2:0]    w_next_raw;
   state_t        w_next;
   logic          w_illegal;

   issue_op_decode u_decode (
      .i_op         (r_op),
      .o_next_state (w_next_raw),
      .o_illegal    (w_illegal)
   );

   assign w_next    = state_t'(w_next_raw);
   assign state_dbg = r_state;

   // Handshake: an instruction transfers on a rising edge where instr_valid
   // and instr_ready are both high; instr_ready is high only while in IDLE.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_op        <= OP_NOP;
         r_tmo       <= '0;
         instr_ready <= 1'b1;
         busy        <= 1'b0;
         rs_address  <= '0;
         rt_address  <= '0;
         rd_address  <= '0;
         data_out    <= '0;
         load        <= 1'b0;
         store       <= 1'b0;
         load_reg_i  <= 1'b0;
         load_rd_i   <= 1'b0;
         alu_start   <= 1'b0;
         illegal_op  <= 1'b0;
         retired     <= '0;
      end else begin
         load       <= 1'b0;
         store      <= 1'b0;
         load_reg_i <= 1'b0;
         load_rd_i  <= 1'b0;
         alu_start  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (instr_valid && instr_ready) begin
                  r_op        <= instr_in[OP_MSB:OP_LSB];
                  rs_address  <= instr_in[RS_MSB:RS_LSB];
                  rt_address  <= instr_in[RT_MSB:RT_LSB];
                  rd_address  <= instr_in[RD_MSB:RD_LSB];
                  // Loaded at accept so the bank sees it stable from DECODE on.
                  if (instr_in[OP_MSB:OP_LSB] == OP_LDI)
                     data_out <= {{(word_size-IMM_W){1'b0}}, instr_in[IMM_MSB:IMM_LSB]};
                  instr_ready <= 1'b0;
                  busy        <= 1'b1;
                  r_state     <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               r_state <= w_next;
               case (w_next)
                  ST_READ:  load       <= 1'b1;
                  ST_MOVE:  load_reg_i <= 1'b1;
                  ST_LDIMM: load_rd_i  <= 1'b1;
                  default: begin
                     instr_ready <= 1'b1;
                     busy        <= 1'b0;
                     if (w_illegal) illegal_op <= 1'b1;
                     else           retired    <= retired + CNT_ONE;
                  end
               endcase
            end
            ST_READ: begin
               if (r_op == OP_RR) begin
                  alu_start <= 1'b1;
                  r_tmo     <= '0;
                  r_state   <= ST_EXEC;
               end else begin
                  instr_ready <= 1'b1;
                  busy        <= 1'b0;
                  retired     <= retired + CNT_ONE;
                  r_state     <= ST_IDLE;
               end
            end
            ST_EXEC: begin
               // A result arriving on the last allowed cycle still wins.
               if (alu_done) begin
                  data_out <= alu_result;
                  store    <= 1'b1;
                  r_state  <= ST_WB;
               end else if (r_tmo == TMO_LAST) begin
                  illegal_op  <= 1'b1;
                  instr_ready <= 1'b1;
                  busy        <= 1'b0;
                  r_state     <= ST_IDLE;
               end else begin
                  r_tmo <= r_tmo + TMO_ONE;
               end
            end
            ST_WB, ST_MOVE, ST_LDIMM: begin
               instr_ready <= 1'b1;
               busy        <= 1'b0;
               retired     <= retired + CNT_ONE;
               r_state     <= ST_IDLE;
            end
            default: begin
               instr_ready <= 1'b1;
               busy        <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_bank_issue_ctrl.sv
// Directed bench for reg_bank_issue_ctrl: reset, LDI, RR (normal, last-cycle
// done, timeout), RD, illegal opcode, MOV and back-to-back NOPs.
module tb_reg_bank_issue_ctrl;

   logic        clock;
   logic        reset;
   logic [31:0] instr_in;
   logic        instr_valid;
   logic        instr_ready;
   logic [4:0]  rs_address;
   logic [4:0]  rt_address;
   logic [4:0]  rd_address;
   logic [31:0] data_out;
   logic        load;
   logic        store;
   logic        load_reg_i;
   logic        load_rd_i;
   logic        alu_start;
   logic [31:0] alu_result;
   logic        alu_done;
   logic        busy;
   logic        illegal_op;
   logic [15:0] retired;
   logic [2:0]  state_dbg;

   int n_tests = 0;
   int n_fail  = 0;
   logic seen_store;
   int n_cyc;

   reg_bank_issue_ctrl dut (
      .clock       (clock),
      .reset       (reset),
      .instr_in    (instr_in),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .rs_address  (rs_address),
      .rt_address  (rt_address),
      .rd_address  (rd_address),
      .data_out    (data_out),
      .load        (load),
      .store       (store),
      .load_reg_i  (load_reg_i),
      .load_rd_i   (load_rd_i),
      .alu_start   (alu_start),
      .alu_result  (alu_result),
      .alu_done    (alu_done),
      .busy        (busy),
      .illegal_op  (illegal_op),
      .retired     (retired),
      .state_dbg   (state_dbg)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [31:0] w);
      instr_in    = w;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #3 reset = 1'b1;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // State codes: IDLE 0, DECODE 1, READ 2, EXEC 3, WB 4, MOVE 5, LDIMM 6
   initial begin
      reset       = 1'b0;
      instr_in    = 32'h0;
      instr_valid = 1'b0;
      alu_result  = 32'h0;
      alu_done    = 1'b0;
      tick();
      check("rst_ready", instr_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_state", state_dbg, 0);
      check("rst_illegal", illegal_op, 0);
      check("rst_retired", retired, 0);
      check("rst_strobes", {load, store, load_reg_i, load_rd_i, alu_start}, 0);
      check("rst_data", data_out, 0);
      #3 reset = 1'b1;
      tick();

      // Reset while an RR sits in EXEC
      issue(32'h04221800);
      tick();
      tick();
      check("mid_alu_start", alu_start, 1);
      check("mid_state_exec", state_dbg, 3);
      tick();
      #2 reset = 1'b0;
      #1;
      check("mid_rst_strobes", {load, store, load_reg_i, load_rd_i, alu_start}, 0);
      check("mid_rst_ready", instr_ready, 1);
      check("mid_rst_state", state_dbg, 0);
      check("mid_rst_retired", retired, 0);
      @(posedge clock);
      #3 reset = 1'b1;
      seen_store = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (store) seen_store = 1'b1;
      end
      check("mid_no_store", seen_store, 0);
      check("mid_retired_after", retired, 0);

      // LDI imm=ABCDE: rd field overlaps imm[15:11] -> 5'd23
      issue(32'h0C0ABCDE);
      check("ldi_decode", state_dbg, 1);
      check("ldi_ready_low", instr_ready, 0);
      check("ldi_busy", busy, 1);
      check("ldi_data_early", data_out, 32'h000ABCDE);
      check("ldi_rd_early", rd_address, 23);
      tick();
      check("ldi_pulse", load_rd_i, 1);
      check("ldi_state", state_dbg, 6);
      check("ldi_only_strobe", {load, store, load_reg_i}, 0);
      tick();
      check("ldi_pulse_end", load_rd_i, 0);
      check("ldi_idle", state_dbg, 0);
      check("ldi_ready", instr_ready, 1);
      check("ldi_retired", retired, 1);

      // LDI imm=A3CDE puts rd=7
      issue(32'h0C0A3CDE);
      tick();
      check("ldi7_pulse", load_rd_i, 1);
      check("ldi7_rd", rd_address, 7);
      check("ldi7_data", data_out, 32'h000A3CDE);
      tick();
      check("ldi7_retired", retired, 2);

      // RR rs=1 rt=2 rd=3, alu_done two cycles after alu_start
      issue(32'h04221800);
      check("rr_decode", state_dbg, 1);
      tick();
      check("rr_load", load, 1);
      check("rr_rs", rs_address, 1);
      check("rr_rt", rt_address, 2);
      check("rr_read", state_dbg, 2);
      tick();
      check("rr_start", alu_start, 1);
      check("rr_load_end", load, 0);
      check("rr_exec", state_dbg, 3);
      tick();
      check("rr_start_end", alu_start, 0);
      tick();
      alu_done   = 1'b1;
      alu_result = 32'h55;
      check("rr_no_early_store", store, 0);
      check("rr_exec2", state_dbg, 3);
      tick();
      alu_done = 1'b0;
      check("rr_store", store, 1);
      check("rr_wb_data", data_out, 32'h55);
      check("rr_wb_rd", rd_address, 3);
      check("rr_wb", state_dbg, 4);
      tick();
      check("rr_store_end", store, 0);
      check("rr_idle", state_dbg, 0);
      check("rr_retired", retired, 3);

      // RR with alu_done on the 15th EXEC cycle
      issue(32'h04221800);
      tick();
      tick();
      for (int i = 0; i < 14; i++) tick();
      alu_done   = 1'b1;
      alu_result = 32'hDEADBEEF;
      check("edge_still_exec", state_dbg, 3);
      tick();
      alu_done = 1'b0;
      check("edge_store", store, 1);
      check("edge_data", data_out, 32'hDEADBEEF);
      check("edge_illegal", illegal_op, 0);
      tick();
      check("edge_retired", retired, 4);

      // RD: operand fetch only
      issue(32'h112A5800);
      tick();
      check("rd_load", load, 1);
      check("rd_rs", rs_address, 9);
      check("rd_rt", rt_address, 10);
      tick();
      check("rd_idle", state_dbg, 0);
      check("rd_no_start", alu_start, 0);
      check("rd_retired", retired, 5);

      // RR timeout: no alu_done at all
      issue(32'h04221800);
      tick();
      tick();
      seen_store = 1'b0;
      for (int i = 0; i < 14; i++) begin
         tick();
         if (store) seen_store = 1'b1;
      end
      check("tmo_last_exec", state_dbg, 3);
      check("tmo_not_yet", illegal_op, 0);
      tick();
      check("tmo_idle", state_dbg, 0);
      check("tmo_illegal", illegal_op, 1);
      check("tmo_store", store | seen_store, 0);
      check("tmo_retired", retired, 5);
      check("tmo_ready", instr_ready, 1);

      do_reset();
      check("rst2_illegal", illegal_op, 0);
      check("rst2_retired", retired, 0);

      // Undefined opcode then MOV rs=4 rt=5
      issue(32'hFC000000);
      check("ill_decode", state_dbg, 1);
      tick();
      check("ill_set", illegal_op, 1);
      check("ill_idle", state_dbg, 0);
      check("ill_retired", retired, 0);
      issue(32'h08850000);
      tick();
      check("mov_pulse", load_reg_i, 1);
      check("mov_rs", rs_address, 4);
      check("mov_rt", rt_address, 5);
      check("mov_state", state_dbg, 5);
      tick();
      check("mov_pulse_end", load_reg_i, 0);
      check("mov_retired", retired, 1);
      check("mov_sticky", illegal_op, 1);

      do_reset();

      // Ten NOPs with instr_valid held high
      instr_in    = 32'h0;
      instr_valid = 1'b1;
      n_cyc = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         n_cyc = i;
         check("nop_state", state_dbg, (i % 2) ? 1 : 0);
         check("nop_ready", instr_ready, (i % 2) ? 0 : 1);
         if (retired == 16'd10) begin
            instr_valid = 1'b0;
            break;
         end
      end
      check("nop_cycles", n_cyc, 20);
      tick();
      tick();
      check("nop_retired", retired, 10);
      check("nop_idle", state_dbg, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
